// File: rtl/div_pkg.sv
// Shared encodings for the iterative RV32M divider: op codes and controller states.
package div_pkg;

  localparam logic [1:0] OP_DIV  = 2'b00;
  localparam logic [1:0] OP_DIVU = 2'b01;
  localparam logic [1:0] OP_REM  = 2'b10;
  localparam logic [1:0] OP_REMU = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } state_t;

endpackage

// File: rtl/div_step.sv
// One restoring-division iteration: shift {rem, quo} left, trial-subtract divisor, restore on borrow.
module div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem,
  input  logic [WIDTH-1:0] quo,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] rem_nx,
  output logic [WIDTH-1:0] quo_nx
);

  // The partial remainder needs one extra bit: a remainder just below a
  // large unsigned divisor overflows WIDTH bits once shifted.
  logic [WIDTH:0]   part;
  logic [WIDTH-1:0] diff;
  logic             fits;

  assign part = {rem, quo[WIDTH-1]};
  assign fits = (part >= {1'b0, divisor});
  assign diff = part[WIDTH-1:0] - divisor;

  always_comb begin
    rem_nx = part[WIDTH-1:0];
    quo_nx = {quo[WIDTH-2:0], 1'b0};
    if (fits) begin
      rem_nx = diff;
      quo_nx = {quo[WIDTH-2:0], 1'b1};
    end
  end

endmodule

// File: rtl/div_unit.sv
// Iterative restoring divider for DIV/DIVU/REM/REMU, one quotient bit per clock.
// Optional DIV_FAST_SPECIAL_EN: divide-by-zero and signed overflow skip RUN (2-cycle latency).
module div_unit
  import div_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  state_t state, state_nx;

  logic [WIDTH-1:0] rem_q, quo_q, dvs_q, a_q;
  logic [WIDTH-1:0] rem_nx, quo_nx, fix_val;
  logic [CW-1:0]    cnt;
  logic             rem_sel, q_neg, r_neg, div0, ovf;
  logic             accept, sgn, in_div0, in_ovf;

  function automatic logic [WIDTH-1:0] neg_if(input logic [WIDTH-1:0] v, input logic neg);
    return neg ? (~v + WIDTH'(1)) : v;
  endfunction

  // Most-negative value maps to unsigned 2^(WIDTH-1), which is the intended magnitude.
  function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] v, input logic is_signed);
    return neg_if(v, is_signed & v[WIDTH-1]);
  endfunction

  assign accept  = start && (state == IDLE || state == DONE);
  assign sgn     = ~op[0];
  assign in_div0 = (b == '0);
  assign in_ovf  = sgn && (a == MIN_NEG) && (b == '1);

  div_step #(.WIDTH(WIDTH)) u_step (
    .rem     (rem_q),
    .quo     (quo_q),
    .divisor (dvs_q),
    .rem_nx  (rem_nx),
    .quo_nx  (quo_nx)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE, DONE: begin
        if (start) begin
`ifdef DIV_FAST_SPECIAL_EN
          state_nx = (in_div0 || in_ovf) ? FIX : RUN;
`else
          state_nx = RUN;
`endif
        end else begin
          state_nx = IDLE;
        end
      end
      RUN:     state_nx = (cnt == '0) ? FIX : RUN;
      FIX:     state_nx = DONE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    busy = (state == RUN) || (state == FIX);
    done = (state == DONE);
  end

  // Special cases override whatever the iteration produced (or skipped).
  always_comb begin
    if (div0)
      fix_val = rem_sel ? a_q : '1;
    else if (ovf)
      fix_val = rem_sel ? '0 : a_q;
    else
      fix_val = rem_sel ? neg_if(rem_q, r_neg) : neg_if(quo_q, q_neg);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rem_q   <= '0;
      quo_q   <= '0;
      dvs_q   <= '0;
      a_q     <= '0;
      cnt     <= '0;
      rem_sel <= 1'b0;
      q_neg   <= 1'b0;
      r_neg   <= 1'b0;
      div0    <= 1'b0;
      ovf     <= 1'b0;
    end else if (accept) begin
      rem_q   <= '0;
      quo_q   <= mag(a, sgn);
      dvs_q   <= mag(b, sgn);
      a_q     <= a;
      cnt     <= CW'(WIDTH - 1);
      rem_sel <= op[1];
      q_neg   <= sgn & (a[WIDTH-1] ^ b[WIDTH-1]);
      r_neg   <= sgn & a[WIDTH-1];
      div0    <= in_div0;
      ovf     <= in_ovf;
    end else if (state == RUN) begin
      rem_q <= rem_nx;
      quo_q <= quo_nx;
      cnt   <= cnt - CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)            result <= '0;
    else if (state == FIX) result <= fix_val;
  end

endmodule
